// File: rtl/issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : issue_ctrl
//  Purpose  : In-order issue controller between fetch and decode. Buffers
//             fetched instructions in a circular FIFO, presents the head to
//             the decoder when its target unit and the ROB can take it,
//             sequences JALR resolution and flushes on clear.
//  Revision : 1.0 - initial release
// ============================================================================
module issue_ctrl #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clear,
  // fetch side
  input  logic              if_valid,
  input  logic [31:0]       if_pc,
  input  logic [31:0]       if_ins,
  input  logic              if_jp,
  output logic              if_stall,
  // decoder side
  output logic              dec_ok,
  output logic [31:0]       dec_pc,
  output logic [31:0]       dec_ins,
  output logic              dec_jp,
  // back-pressure from downstream units
  input  logic              rs_full,
  input  logic              lsb_full,
  input  logic              rob_full,
  input  logic              jalr_ok,
  // status
  output logic [ADDR_W:0]   occ
);

  // Major opcodes used to route the head instruction
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_JWAIT = 1'b1
  } state_t;

  // Storage (not reset; only read when the entry is valid)
  logic [31:0]       pc_mem  [DEPTH];
  logic [31:0]       ins_mem [DEPTH];
  logic              jp_mem  [DEPTH];

  logic [ADDR_W-1:0] head_q, head_d;
  logic [ADDR_W-1:0] tail_q, tail_d;
  logic [ADDR_W:0]   count_q, count_d;
  state_t            state_q, state_d;

  logic              full;
  logic              empty;
  logic              jalr_pend;
  logic [6:0]        head_op;
  logic              head_is_jalr;
  logic              unit_free;
  logic              push;
  logic              pop;

  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign jalr_pend = (state_q == ST_JWAIT);

  assign dec_pc  = pc_mem[head_q];
  assign dec_ins = ins_mem[head_q];
  assign dec_jp  = jp_mem[head_q];
  assign head_op = ins_mem[head_q][6:0];
  assign head_is_jalr = (head_op == OP_JALR);

  // Classify the head and decide whether its destination can accept it
  always_comb begin
    unit_free = 1'b1;
    unique case (head_op)
      OP_LOAD, OP_STORE:          unit_free = !lsb_full && !rob_full;
      OP_REG, OP_IMM, OP_BRANCH:  unit_free = !rs_full && !rob_full;
      OP_LUI, OP_AUIPC, OP_JAL,
      OP_JALR:                    unit_free = !rob_full;
      default:                    unit_free = 1'b1;  // illegal: decoder drops it
    endcase
  end

  assign dec_ok = rdy && !clear && !empty && unit_free;

  // JALR stays at the head until the decoder reports its target resolved
  assign pop  = dec_ok && (!head_is_jalr || jalr_ok);
  assign push = rdy && !clear && if_valid && !full && (state_q == ST_RUN);

  assign if_stall = full || jalr_pend;
  assign occ      = count_q;

  // Next pointers, count and FSM state; clear overrides everything
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    state_d = state_q;
    if (clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      state_d = ST_RUN;
    end else begin
      if (push) tail_d = tail_q + ADDR_W'(1);
      if (pop)  head_d = head_q + ADDR_W'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + (ADDR_W+1)'(1);
        2'b01:   count_d = count_q - (ADDR_W+1)'(1);
        default: count_d = count_q;
      endcase
      unique case (state_q)
        ST_RUN: begin
          if (push && (if_ins[6:0] == OP_JALR)) state_d = ST_JWAIT;
        end
        ST_JWAIT: begin
          if (pop && head_is_jalr) state_d = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= ST_RUN;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  // FIFO payload write at the tail
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail_q]  <= if_pc;
      ins_mem[tail_q] <= if_ins;
      jp_mem[tail_q]  <= if_jp;
    end
  end

endmodule
`default_nettype wire
